ccr_unit: RTL

- Condition-code register and flag consumer for the VCPU datapath.
- Accepts the ALU's XNZVC result and change mask, and merges them into an architectural 5-bit CCR.
- Supports explicit CCR writes (MOVE/AND/OR/EOR to CCR) and a one-entry exception shadow.
- Feeds X back to the ALU's in_X and evaluates the 16 68k branch conditions for the sequencer.

---
 rtl/ccr_unit_pkg.sv | 46 ++++
 rtl/ccr_unit_if.sv | 38 +++
 rtl/ccr_cond_eval.sv | 45 ++++
 rtl/ccr_unit.sv | 91 +++++++++
 4 files changed

// File: rtl/ccr_unit_pkg.sv
// ccr_unit_pkg: shared definitions for the VCPU condition-code logic.
// Holds the XNZVC bit positions, the explicit-write opcodes, the 68k Bcc
// condition encodings and the helper that applies an explicit CCR write.
package ccr_unit_pkg;

    // Bit positions inside the 5-bit CCR (order XNZVC)
    localparam int BITPOS_X = 4;
    localparam int BITPOS_N = 3;
    localparam int BITPOS_Z = 2;
    localparam int BITPOS_V = 1;
    localparam int BITPOS_C = 0;

    typedef enum logic [1:0] {
        WR_MOVE = 2'd0,
        WR_AND  = 2'd1,
        WR_OR   = 2'd2,
        WR_EOR  = 2'd3
    } wr_op_e;

    typedef enum logic [3:0] {
        COND_T  = 4'd0,  COND_F  = 4'd1,
        COND_HI = 4'd2,  COND_LS = 4'd3,
        COND_CC = 4'd4,  COND_CS = 4'd5,
        COND_NE = 4'd6,  COND_EQ = 4'd7,
        COND_VC = 4'd8,  COND_VS = 4'd9,
        COND_PL = 4'd10, COND_MI = 4'd11,
        COND_GE = 4'd12, COND_LT = 4'd13,
        COND_GT = 4'd14, COND_LE = 4'd15
    } cond_e;

    // Explicit CCR write: all five bits are replaced, the ALU mask plays no part
    function automatic logic [4:0] apply_write(input logic [4:0] ccr,
                                               input wr_op_e     op,
                                               input logic [4:0] data);
        logic [4:0] res;
        case (op)
            WR_MOVE: res = data;
            WR_AND:  res = ccr & data;
            WR_OR:   res = ccr | data;
            WR_EOR:  res = ccr ^ data;
            default: res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ccr_unit_if.sv
// ccr_unit_if: bundle of the flag-update, write, shadow and condition
// signals between the datapath/sequencer (master) and ccr_unit (slave).
//   in_ALU_*  : ALU flag result, change mask, Z-accumulate mode and strobe
//   in_WR_*   : explicit CCR write strobe, opcode and operand
//   in_SAVE / in_RESTORE : exception shadow copy / reload
//   in_COND   : Bcc condition selector
//   out_CCR, out_X, out_COND_TRUE, out_CONFLICT : results back to the core
interface ccr_unit_if;
    import ccr_unit_pkg::*;

    logic       in_ALU_VALID;
    logic [4:0] in_ALU_XNZVC;
    logic [4:0] in_ALU_CHG;
    logic       in_ALU_ZACC;
    logic       in_WR_EN;
    logic [1:0] in_WR_OP;
    logic [4:0] in_WR_DATA;
    logic       in_SAVE;
    logic       in_RESTORE;
    logic [3:0] in_COND;
    logic [4:0] out_CCR;
    logic       out_X;
    logic       out_COND_TRUE;
    logic       out_CONFLICT;

    modport master (
        output in_ALU_VALID, in_ALU_XNZVC, in_ALU_CHG, in_ALU_ZACC,
        output in_WR_EN, in_WR_OP, in_WR_DATA, in_SAVE, in_RESTORE, in_COND,
        input  out_CCR, out_X, out_COND_TRUE, out_CONFLICT
    );

    modport slave (
        input  in_ALU_VALID, in_ALU_XNZVC, in_ALU_CHG, in_ALU_ZACC,
        input  in_WR_EN, in_WR_OP, in_WR_DATA, in_SAVE, in_RESTORE, in_COND,
        output out_CCR, out_X, out_COND_TRUE, out_CONFLICT
    );

endinterface

// File: rtl/ccr_cond_eval.sv
// ccr_cond_eval: combinational evaluation of the 16 68k branch conditions.
// Shared with the sequencer for DBcc/Scc.
//   ccr       : 5-bit CCR (XNZVC)
//   cond      : 4-bit Bcc condition code
//   cond_true : 1 when the condition holds
module ccr_cond_eval
    import ccr_unit_pkg::*;
(
    input  logic [4:0] ccr,
    input  logic [3:0] cond,
    output logic       cond_true
);

    logic n_s, z_s, v_s, c_s;

    assign n_s = ccr[BITPOS_N];
    assign z_s = ccr[BITPOS_Z];
    assign v_s = ccr[BITPOS_V];
    assign c_s = ccr[BITPOS_C];

    // Condition decode
    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond))
            COND_T:  cond_true = 1'b1;
            COND_F:  cond_true = 1'b0;
            COND_HI: cond_true = ~c_s & ~z_s;
            COND_LS: cond_true = c_s | z_s;
            COND_CC: cond_true = ~c_s;
            COND_CS: cond_true = c_s;
            COND_NE: cond_true = ~z_s;
            COND_EQ: cond_true = z_s;
            COND_VC: cond_true = ~v_s;
            COND_VS: cond_true = v_s;
            COND_PL: cond_true = ~n_s;
            COND_MI: cond_true = n_s;
            COND_GE: cond_true = n_s ~^ v_s;
            COND_LT: cond_true = n_s ^ v_s;
            COND_GT: cond_true = ~z_s & (n_s ~^ v_s);
            COND_LE: cond_true = z_s | (n_s ^ v_s);
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/ccr_unit.sv
// ccr_unit: architectural condition-code register for the VCPU datapath.
// Merges masked ALU flag updates (with ADDX/SUBX-style Z accumulation),
// applies explicit MOVE/AND/OR/EOR writes, keeps a one-entry exception
// shadow and evaluates the Bcc condition for the sequencer.
//   in_CLK     : clock, rising edge
//   in_RESET   : asynchronous active-low reset
//   bus        : ccr_unit_if slave modport (all data/control/result signals)
// Parameters: RESET_CCR (CCR after reset), FORWARD (1 = out_X/out_COND_TRUE
// look at the next-state CCR instead of the registered one).
module ccr_unit
    import ccr_unit_pkg::*;
#(
    parameter logic [4:0] RESET_CCR = 5'b00000,
    parameter bit         FORWARD   = 1'b0
) (
    input  logic        in_CLK,
    input  logic        in_RESET,
    ccr_unit_if.slave   bus
);

    logic [4:0] ccr_r;
    logic [4:0] shadow_r;
    logic       conflict_r;

    logic [4:0] alu_merge_s;
    logic       z_merge_s;
    logic [4:0] ccr_next_s;
    logic [4:0] shadow_next_s;
    logic       conflict_next_s;
    logic [4:0] sel_ccr_s;

    // Masked ALU merge; Z-accumulate can only keep or clear Z, never set it
    always_comb begin
        alu_merge_s = (bus.in_ALU_XNZVC & bus.in_ALU_CHG) | (ccr_r & ~bus.in_ALU_CHG);
        if (bus.in_ALU_CHG[BITPOS_Z] && bus.in_ALU_ZACC) begin
            z_merge_s = ccr_r[BITPOS_Z] & bus.in_ALU_XNZVC[BITPOS_Z];
        end else begin
            z_merge_s = alu_merge_s[BITPOS_Z];
        end
        alu_merge_s[BITPOS_Z] = z_merge_s;
    end

    // Next-state selection: restore beats explicit write beats ALU update
    always_comb begin
        ccr_next_s      = ccr_r;
        shadow_next_s   = shadow_r;
        conflict_next_s = bus.in_ALU_VALID & (bus.in_WR_EN | bus.in_RESTORE);
        if (bus.in_RESTORE) begin
            ccr_next_s = shadow_r;
        end else if (bus.in_WR_EN) begin
            ccr_next_s = apply_write(ccr_r, wr_op_e'(bus.in_WR_OP), bus.in_WR_DATA);
        end else if (bus.in_ALU_VALID) begin
            ccr_next_s = alu_merge_s;
        end else begin
            ccr_next_s = ccr_r;
        end
        // Save always captures the pre-edge CCR, so SAVE+RESTORE is a swap
        if (bus.in_SAVE) begin
            shadow_next_s = ccr_r;
        end else begin
            shadow_next_s = shadow_r;
        end
    end

    // CCR, shadow and conflict-pulse registers
    always_ff @(posedge in_CLK or negedge in_RESET) begin
        if (!in_RESET) begin
            ccr_r      <= RESET_CCR;
            shadow_r   <= 5'b00000;
            conflict_r <= 1'b0;
        end else begin
            ccr_r      <= ccr_next_s;
            shadow_r   <= shadow_next_s;
            conflict_r <= conflict_next_s;
        end
    end

    // FORWARD=1 exposes the flags being written this cycle to the sequencer
    assign sel_ccr_s = FORWARD ? ccr_next_s : ccr_r;

    ccr_cond_eval u_cond_eval (
        .ccr       (sel_ccr_s),
        .cond      (bus.in_COND),
        .cond_true (bus.out_COND_TRUE)
    );

    assign bus.out_CCR      = ccr_r;
    assign bus.out_X        = sel_ccr_s[BITPOS_X];
    assign bus.out_CONFLICT = conflict_r;

endmodule
